multi_port_rob: RTL

MULTI_PORT_ROB -- requirements
Module: multi_port_rob

---
 rtl/multi_port_rob_pkg.sv | 12 +
 rtl/rob_commit_select.sv | 24 ++
 rtl/multi_port_rob.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/multi_port_rob_pkg.sv
// Shared defaults for the multi-port reorder buffer.
// Holds the default entry-address, register-index, PC and finish-port widths
// used as parameter defaults by multi_port_rob and its sub-modules.
package multi_port_rob_pkg;

  localparam int unsigned ROB_SEL_DEF   = 6;
  localparam int unsigned ROB_NUM_DEF   = 1 << ROB_SEL_DEF;
  localparam int unsigned REG_SEL_DEF   = 5;
  localparam int unsigned INSN_LEN_DEF  = 32;
  localparam int unsigned FIN_PORTS_DEF = 4;

endpackage

// File: rtl/rob_commit_select.sv
// Two-slot in-order commit selection for the reorder buffer.
// Ports:
//   flush                      - suppresses all commits this cycle
//   head_valid/head_finished   - state of the entry at the head
//   next_valid/next_finished   - state of the entry at head+1
//   commit1_c/commit2_c        - head / head+1 commit this cycle
//   comnum_c                   - number of entries committing (0..2)
module rob_commit_select (
  input  logic       flush,
  input  logic       head_valid,
  input  logic       head_finished,
  input  logic       next_valid,
  input  logic       next_finished,
  output logic       commit1_c,
  output logic       commit2_c,
  output logic [1:0] comnum_c
);

  // The second slot may only retire behind the first to keep program order.
  assign commit1_c = ~flush & head_valid & head_finished;
  assign commit2_c = commit1_c & next_valid & next_finished;
  assign comnum_c  = 2'(commit1_c) + 2'(commit2_c);

endmodule

// File: rtl/multi_port_rob.sv
// Multi-port reorder buffer: two dispatch slots, FIN_PORTS finish ports,
// up to two in-order commits per cycle.
// Ports:
//   clk, reset                      - clock, synchronous active-high reset
//   dp1_*/dp2_*                     - dispatch slots (slot 2 requires slot 1)
//   finish_ex_i/finish_ex_addr_i    - per-port finish strobes and entry addresses
//   flush_i                         - discard all in-flight entries
//   commit_ptr_1_o/commit_ptr_2_o   - head and head+1
//   comnum_o, arfwe_*_o, dst_arf_*_o, pc_com_1_o - commit information
//   count_o, full_o                 - occupancy and near-full indication
module multi_port_rob
  import multi_port_rob_pkg::*;
#(
  parameter int unsigned ROB_SEL   = ROB_SEL_DEF,
  parameter int unsigned REG_SEL   = REG_SEL_DEF,
  parameter int unsigned INSN_LEN  = INSN_LEN_DEF,
  parameter int unsigned FIN_PORTS = FIN_PORTS_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         dp1_i,
  input  logic                         dp2_i,
  input  logic [ROB_SEL-1:0]           dp1_addr_i,
  input  logic [ROB_SEL-1:0]           dp2_addr_i,
  input  logic [INSN_LEN-1:0]          pc_dp1_i,
  input  logic [INSN_LEN-1:0]          pc_dp2_i,
  input  logic                         dstvalid_dp1_i,
  input  logic                         dstvalid_dp2_i,
  input  logic [REG_SEL-1:0]           dst_dp1_i,
  input  logic [REG_SEL-1:0]           dst_dp2_i,
  input  logic [FIN_PORTS-1:0]         finish_ex_i,
  input  logic [FIN_PORTS*ROB_SEL-1:0] finish_ex_addr_i,
  input  logic                         flush_i,
  output logic [ROB_SEL-1:0]           commit_ptr_1_o,
  output logic [ROB_SEL-1:0]           commit_ptr_2_o,
  output logic [1:0]                   comnum_o,
  output logic                         arfwe_1_o,
  output logic                         arfwe_2_o,
  output logic [REG_SEL-1:0]           dst_arf_1_o,
  output logic [REG_SEL-1:0]           dst_arf_2_o,
  output logic [INSN_LEN-1:0]          pc_com_1_o,
  output logic [ROB_SEL:0]             count_o,
  output logic                         full_o
);

  localparam int unsigned ROB_NUM = 1 << ROB_SEL;
  localparam int unsigned CNT_W   = ROB_SEL + 1;

  // Entry state
  logic [ROB_NUM-1:0]  valid;
  logic [ROB_NUM-1:0]  finished;
  logic [ROB_NUM-1:0]  dstvalid_q;
  logic [INSN_LEN-1:0] pc_q  [ROB_NUM];
  logic [REG_SEL-1:0]  dst_q [ROB_NUM];

  logic [ROB_SEL-1:0]  head;
  logic [ROB_SEL-1:0]  head_p1;
  logic [CNT_W-1:0]    count;

  logic                commit1;
  logic                commit2;
  logic [1:0]          comnum;
  logic [CNT_W-1:0]    disp_cnt;

  logic [ROB_NUM-1:0]  fin_hit;
  logic [ROB_NUM-1:0]  disp_hit;
  logic [ROB_NUM-1:0]  com_hit;

  assign head_p1 = head + ROB_SEL'(1);

  rob_commit_select u_commit_select (
    .flush         (flush_i),
    .head_valid    (valid[head]),
    .head_finished (finished[head]),
    .next_valid    (valid[head_p1]),
    .next_finished (finished[head_p1]),
    .commit1_c     (commit1),
    .commit2_c     (commit2),
    .comnum_c      (comnum)
  );

  // Per-entry one-hot decode of finish, dispatch and commit events.
  always_comb begin
    fin_hit  = '0;
    disp_hit = '0;
    com_hit  = '0;
    for (int k = 0; k < int'(FIN_PORTS); k++) begin
      if (finish_ex_i[k]) begin
        fin_hit[finish_ex_addr_i[k*ROB_SEL +: ROB_SEL]] = 1'b1;
      end
    end
    if (dp1_i) begin
      disp_hit[dp1_addr_i] = 1'b1;
      if (dp2_i) begin
        disp_hit[dp2_addr_i] = 1'b1;
      end
    end
    if (commit1) com_hit[head]    = 1'b1;
    if (commit2) com_hit[head_p1] = 1'b1;
  end

  assign disp_cnt = CNT_W'(dp1_i) + CNT_W'(dp1_i & dp2_i);

  // Control state: dispatch wins over a same-cycle finish on the same entry,
  // and finishes are only accepted on entries already valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid    <= '0;
      finished <= '0;
      head     <= '0;
      count    <= '0;
    end else if (flush_i) begin
      valid    <= '0;
      finished <= '0;
      count    <= '0;
    end else begin
      valid    <= (valid & ~com_hit) | disp_hit;
      finished <= (finished | (fin_hit & valid)) & ~com_hit & ~disp_hit;
      head     <= head + ROB_SEL'(comnum);
      count    <= count + disp_cnt - CNT_W'(comnum);
    end
  end

  // Payload storage; writes while reset/flush are harmless as valid is cleared.
  always_ff @(posedge clk) begin
    if (dp1_i) begin
      pc_q[dp1_addr_i]       <= pc_dp1_i;
      dstvalid_q[dp1_addr_i] <= dstvalid_dp1_i;
      dst_q[dp1_addr_i]      <= dst_dp1_i;
      if (dp2_i) begin
        pc_q[dp2_addr_i]       <= pc_dp2_i;
        dstvalid_q[dp2_addr_i] <= dstvalid_dp2_i;
        dst_q[dp2_addr_i]      <= dst_dp2_i;
      end
    end
  end

  assign commit_ptr_1_o = head;
  assign commit_ptr_2_o = head_p1;
  assign comnum_o       = comnum;
  assign arfwe_1_o      = commit1 & dstvalid_q[head];
  assign arfwe_2_o      = commit2 & dstvalid_q[head_p1];
  assign dst_arf_1_o    = dst_q[head];
  assign dst_arf_2_o    = dst_q[head_p1];
  assign pc_com_1_o     = pc_q[head];
  assign count_o        = count;
  assign full_o         = count > CNT_W'(ROB_NUM - 2);

endmodule
